// File: rtl/fir_pkg.sv
// Shared FIR output-path constants and the byte streamer state encoding.
package fir_pkg;

   localparam int BYTE_MAX = 127;
   localparam int BYTE_MIN = -128;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GAP_WAIT = 2'd1,
      DONE     = 2'd2
   } streamer_state_e;

endpackage

// File: rtl/fir_byte_streamer_if.sv
// Input handshake of the FIR byte streamer: wide signed samples over valid/ready.
interface fir_byte_streamer_if #(
   parameter int IN_W = 24
) ();

   logic                   in_valid;
   logic                   in_ready;
   logic signed [IN_W-1:0] in_data;

   modport master (output in_valid, output in_data, input  in_ready);
   modport slave  (input  in_valid, input  in_data, output in_ready);

endinterface

// File: rtl/fir_sat_round.sv
// Round-half-up, arithmetic shift and clamp of a wide signed value to a signed byte.
module fir_sat_round
   import fir_pkg::*;
#(
   parameter int IN_W  = 24,
   parameter int SHIFT = 8
) (
   input  logic signed [IN_W-1:0] din,
   output logic        [7:0]      dout,
   output logic                   sat
);

   localparam int                 RS  = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [IN_W:0] RND = (SHIFT > 0) ? ((IN_W+1)'(1) << RS) : '0;
   localparam logic signed [IN_W:0] HI  = (IN_W+1)'(BYTE_MAX);
   localparam logic signed [IN_W:0] LO  = (IN_W+1)'(BYTE_MIN);

   logic signed [IN_W:0] sum;
   logic signed [IN_W:0] t;

   // One extra bit of headroom so adding the rounding constant never wraps.
   always_comb begin
      sum = {din[IN_W-1], din} + RND;
      t   = sum >>> SHIFT;
      sat = 1'b1;
      if (t > HI) begin
         dout = 8'(BYTE_MAX);
      end else if (t < LO) begin
         dout = 8'(BYTE_MIN);
      end else begin
         dout = t[7:0];
         sat  = 1'b0;
      end
   end

endmodule

// File: rtl/fir_byte_streamer.sv
// FIR output stage: converts samples to bytes, queues them and emits a paced dv/data stream.
// Optional saturation counter enabled by defining STREAMER_SAT_STATS_EN.
module fir_byte_streamer
   import fir_pkg::*;
#(
   parameter int IN_W      = 24,
   parameter int SHIFT     = 8,
   parameter int DEPTH     = 4,
   parameter int FRAME_LEN = 1024,
   parameter int GAP       = 0
) (
   input  logic                  clk,
   input  logic                  rstx,
   fir_byte_streamer_if.slave    src,
   output logic                  dv,
   output logic [7:0]            data,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           frame_cnt
`ifdef STREAMER_SAT_STATS_EN
   ,
   output logic [15:0]           sat_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);

   streamer_state_e state;
   logic [7:0]      mem [DEPTH];
   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;
   logic [AW:0]     count;
   logic [7:0]      gap_cnt;
   logic [7:0]      conv_byte;
   logic            wr;
`ifdef STREAMER_SAT_STATS_EN
   logic            conv_sat;
`else
   logic            conv_sat_unused;
`endif

   fir_sat_round #(
      .IN_W  (IN_W),
      .SHIFT (SHIFT)
   ) u_conv (
      .din  (src.in_data),
`ifdef STREAMER_SAT_STATS_EN
      .sat  (conv_sat),
`else
      .sat  (conv_sat_unused),
`endif
      .dout (conv_byte)
   );

   assign count        = wr_ptr - rd_ptr;
   // Gating with rstx keeps the source stalled while the block is held in reset.
   assign src.in_ready = rstx & (count != (AW+1)'(DEPTH)) & ~done;
   assign wr           = src.in_valid & src.in_ready;
   assign busy         = (count != '0) | (state == GAP_WAIT);

   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr[AW-1:0]] <= conv_byte;
   end

   always_ff @(posedge clk or negedge rstx) begin
      if (!rstx) begin
         state     <= IDLE;
         dv        <= 1'b0;
         data      <= '0;
         done      <= 1'b0;
         frame_cnt <= '0;
         gap_cnt   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         case (state)
            IDLE: begin
               dv <= 1'b0;
               if (count != '0) begin
                  rd_ptr <= rd_ptr + 1'b1;
                  dv     <= 1'b1;
                  data   <= mem[rd_ptr[AW-1:0]];
                  if (frame_cnt != '1) frame_cnt <= frame_cnt + 16'd1;
                  if (FRAME_LEN != 0 && frame_cnt + 16'd1 == 16'(FRAME_LEN)) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else if (GAP > 0) begin
                     state   <= GAP_WAIT;
                     gap_cnt <= 8'(GAP);
                  end
               end
            end
            GAP_WAIT: begin
               dv      <= 1'b0;
               gap_cnt <= gap_cnt - 8'd1;
               if (gap_cnt <= 8'd1) state <= IDLE;
            end
            DONE: begin
               dv   <= 1'b0;
               done <= 1'b1;
            end
            default: begin
               state <= IDLE;
               dv    <= 1'b0;
            end
         endcase
      end
   end

`ifdef STREAMER_SAT_STATS_EN
   always_ff @(posedge clk or negedge rstx) begin
      if (!rstx) begin
         sat_cnt <= '0;
      end else if (wr && conv_sat && sat_cnt != '1) begin
         sat_cnt <= sat_cnt + 16'd1;
      end
   end
`endif

endmodule
